clock_mode_ctrl: RTL

Mode controller and tick scheduler for the stopwatch time core. It turns the debounced PAUSE button and the adjust/select switches into the control strobes the counter datapath consumes: `tick_active`, `count_enable`, `use_2hz`, `sel_minutes`, `sel_seconds`, `adj_step_hold` and `adj_step_pulse`. It owns the 1 Hz/2 Hz timebase, the RUN/PAUSED/ADJUST state machine, and tap-versus-hold discrimination on PAUSE. It sits between the input debouncers and the time core.

---
 rtl/clock_mode_ctrl_if.sv | 29 ++
 rtl/clock_mode_ctrl.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/clock_mode_ctrl_if.sv
// Control bundle between the debounced front panel and the stopwatch mode controller.
// The master drives the buttons and switches; the slave returns the strobes for the time core.
interface clock_mode_ctrl_if;
   logic btn_pause;
   logic sw_adj;
   logic sw_sel;
   logic tick_active;
   logic tick_1hz;
   logic tick_2hz;
   logic count_enable;
   logic use_2hz;
   logic sel_minutes;
   logic sel_seconds;
   logic adj_step_pulse;
   logic adj_step_hold;
   logic blink;

   modport master (
      output btn_pause, sw_adj, sw_sel,
      input  tick_active, tick_1hz, tick_2hz, count_enable, use_2hz,
             sel_minutes, sel_seconds, adj_step_pulse, adj_step_hold, blink
   );

   modport slave (
      input  btn_pause, sw_adj, sw_sel,
      output tick_active, tick_1hz, tick_2hz, count_enable, use_2hz,
             sel_minutes, sel_seconds, adj_step_pulse, adj_step_hold, blink
   );
endinterface

// File: rtl/clock_mode_ctrl.sv
// Stopwatch mode controller: RUN/PAUSED/ADJUST state machine, 1 Hz/2 Hz tick scheduler
// and tap-versus-hold discrimination of the PAUSE button while adjusting.
module clock_mode_ctrl #(
   parameter int DIV_2HZ     = 50_000_000,
   parameter int HOLD_CYCLES = 50_000_000
) (
   input  logic            clk,
   input  logic            rst,
   clock_mode_ctrl_if.slave bus
);

   localparam int DIV_W  = $clog2(DIV_2HZ);
   localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

   localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(DIV_2HZ - 1);
   localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYCLES);

   localparam logic [1:0] ST_RUN    = 2'd0;
   localparam logic [1:0] ST_PAUSED = 2'd1;
   localparam logic [1:0] ST_ADJUST = 2'd2;

   function automatic logic [HOLD_W-1:0] sat_inc(input logic [HOLD_W-1:0] v);
      return (v == HOLD_MAX) ? v : v + 1'b1;
   endfunction

   logic [1:0]        state;
   logic [1:0]        resume;
   logic              btn_q;
   logic              adj_q;
   logic [DIV_W-1:0]  div_cnt;
   logic              half;
   logic [HOLD_W-1:0] hold_cnt;

   logic tick_1hz_r;
   logic tick_2hz_r;
   logic count_enable_r;
   logic use_2hz_r;
   logic sel_minutes_r;
   logic sel_seconds_r;
   logic step_pulse_r;
   logic step_hold_r;
   logic blink_r;

   logic              press;
   logic              adj_rise;
   logic              adj_fall;
   logic [1:0]        state_nxt;
   logic [1:0]        resume_nxt;
   logic              transition;
   logic              in_adjust;
   logic              run_tb;
   logic              wrap;
   logic [DIV_W-1:0]  div_nxt;
   logic              half_nxt;
   logic [HOLD_W-1:0] hold_nxt;
   logic              step_hold_nxt;

   assign press    = bus.btn_pause & ~btn_q;
   assign adj_rise = bus.sw_adj & ~adj_q;
   assign adj_fall = ~bus.sw_adj & adj_q;

   // Adjust-switch edges outrank PAUSE presses, so a coincident press is simply dropped.
   always_comb begin
      state_nxt  = state;
      resume_nxt = resume;
      case (state)
         ST_RUN: begin
            if (adj_rise) begin
               state_nxt  = ST_ADJUST;
               resume_nxt = ST_RUN;
            end else if (press) begin
               state_nxt = ST_PAUSED;
            end
         end
         ST_PAUSED: begin
            if (adj_rise) begin
               state_nxt  = ST_ADJUST;
               resume_nxt = ST_PAUSED;
            end else if (press) begin
               state_nxt = ST_RUN;
            end
         end
         ST_ADJUST: begin
            if (adj_fall) begin
               state_nxt = resume;
            end
         end
         default: begin
            state_nxt  = ST_PAUSED;
            resume_nxt = ST_PAUSED;
         end
      endcase
   end

   assign transition = (state_nxt != state);
   assign in_adjust  = (state == ST_ADJUST) & ~transition;

   // The divider is parked while PAUSED and restarts from zero on every mode change,
   // which also swallows any tick that would have landed on the transition cycle.
   always_comb begin
      run_tb   = ~transition & (state != ST_PAUSED);
      wrap     = run_tb & (div_cnt == DIV_LAST);
      div_nxt  = (!run_tb || wrap) ? '0 : div_cnt + 1'b1;
      half_nxt = run_tb ? (half ^ wrap) : 1'b0;
   end

   always_comb begin
      hold_nxt = '0;
      if (in_adjust && bus.btn_pause && !press) begin
         hold_nxt = sat_inc(hold_cnt);
      end
      step_hold_nxt = in_adjust & bus.btn_pause & (hold_nxt == HOLD_MAX);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= ST_PAUSED;
         resume         <= ST_PAUSED;
         btn_q          <= 1'b0;
         adj_q          <= 1'b0;
         div_cnt        <= '0;
         half           <= 1'b0;
         hold_cnt       <= '0;
         tick_1hz_r     <= 1'b0;
         tick_2hz_r     <= 1'b0;
         count_enable_r <= 1'b0;
         use_2hz_r      <= 1'b0;
         sel_minutes_r  <= 1'b0;
         sel_seconds_r  <= 1'b0;
         step_pulse_r   <= 1'b0;
         step_hold_r    <= 1'b0;
         blink_r        <= 1'b0;
      end else begin
         state          <= state_nxt;
         resume         <= resume_nxt;
         btn_q          <= bus.btn_pause;
         adj_q          <= bus.sw_adj;
         div_cnt        <= div_nxt;
         half           <= half_nxt;
         hold_cnt       <= hold_nxt;
         tick_2hz_r     <= wrap;
         tick_1hz_r     <= wrap & half;
         count_enable_r <= (state_nxt == ST_RUN);
         use_2hz_r      <= (state_nxt == ST_ADJUST);
         sel_minutes_r  <= (state_nxt == ST_ADJUST) & ~bus.sw_sel;
         sel_seconds_r  <= (state_nxt == ST_ADJUST) & bus.sw_sel;
         step_pulse_r   <= in_adjust & press;
         step_hold_r    <= step_hold_nxt;
         blink_r        <= in_adjust & (blink_r ^ wrap);
      end
   end

   assign bus.tick_1hz       = tick_1hz_r;
   assign bus.tick_2hz       = tick_2hz_r;
   assign bus.tick_active    = use_2hz_r ? tick_2hz_r : tick_1hz_r;
   assign bus.count_enable   = count_enable_r;
   assign bus.use_2hz        = use_2hz_r;
   assign bus.sel_minutes    = sel_minutes_r;
   assign bus.sel_seconds    = sel_seconds_r;
   assign bus.adj_step_pulse = step_pulse_r;
   assign bus.adj_step_hold  = step_hold_r;
   assign bus.blink          = blink_r;

endmodule
